// File: rtl/pbvi_iter_ctrl_if.sv
// Stage handshake bundle between the PBVI iteration sequencer
// and the three backup stages plus the alpha store strobe.
interface pbvi_iter_ctrl_if;
    logic s1_en;
    logic s2_en;
    logic s3_en;
    logic alpha_we;
    logic s1_done;
    logic s2_done;
    logic s3_done;

    modport master (
        output s1_en, s2_en, s3_en, alpha_we,
        input  s1_done, s2_done, s3_done
    );

    modport slave (
        input  s1_en, s2_en, s3_en, alpha_we,
        output s1_done, s2_done, s3_done
    );
endinterface

// File: rtl/pbvi_iter_ctrl.sv
// PBVI value-backup sequencer: runs stages 1-3 per iteration,
// commits alpha, and stops on limit, convergence, abort or hang.
module pbvi_iter_ctrl #(
    parameter int ITER_W  = 8,
    parameter int TO_W    = 6,
    parameter int TIMEOUT = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              converged,
    pbvi_iter_ctrl_if.master  stg,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ITER_W-1:0] iter_cnt
);
    typedef enum logic [3:0] {
        IDLE, S1_GO, S1_WAIT, S2_GO, S2_WAIT,
        S3_GO, S3_WAIT, COMMIT, CHECK, FIN
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ITER_W-1:0] limit;
    logic [TO_W-1:0]   wdog;
    logic [2:0]        done_prev;
    logic [2:0]        done_rise;
    logic              in_wait;
    logic              in_go;
    logic              stage_hit;
    logic              tmo;
    logic              accept;

    // only a fresh 0->1 edge counts, so a stale-high done is ignored
    assign done_rise = {stg.s3_done, stg.s2_done, stg.s1_done} & ~done_prev;
    assign accept    = (state == IDLE) && start;
    assign tmo       = in_wait && !stage_hit && (wdog == WD_LAST);

    always_comb begin
        in_wait   = 1'b0;
        in_go     = 1'b0;
        stage_hit = 1'b0;
        unique case (state)
            S1_GO, S2_GO, S3_GO: in_go = 1'b1;
            S1_WAIT: begin
                in_wait   = 1'b1;
                stage_hit = done_rise[0];
            end
            S2_WAIT: begin
                in_wait   = 1'b1;
                stage_hit = done_rise[1];
            end
            S3_WAIT: begin
                in_wait   = 1'b1;
                stage_hit = done_rise[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) state_nxt = (max_iter == '0) ? FIN : S1_GO;
                S1_GO: state_nxt = S1_WAIT;
                S1_WAIT: begin
                    if (stage_hit) state_nxt = S2_GO;
                    else if (tmo)  state_nxt = IDLE;
                end
                S2_GO: state_nxt = S2_WAIT;
                S2_WAIT: begin
                    if (stage_hit) state_nxt = S3_GO;
                    else if (tmo)  state_nxt = IDLE;
                end
                S3_GO: state_nxt = S3_WAIT;
                S3_WAIT: begin
                    if (stage_hit) state_nxt = COMMIT;
                    else if (tmo)  state_nxt = IDLE;
                end
                COMMIT: state_nxt = CHECK;
                CHECK: begin
                    if (converged || iter_cnt == limit) state_nxt = FIN;
                    else                                state_nxt = S1_GO;
                end
                FIN: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limit     <= '0;
            iter_cnt  <= '0;
            err       <= 1'b0;
            wdog      <= '0;
            done_prev <= '0;
        end else begin
            done_prev <= {stg.s3_done, stg.s2_done, stg.s1_done};
            if (accept) begin
                limit    <= max_iter;
                iter_cnt <= '0;
                err      <= 1'b0;
            end
            // abort freezes every side effect of the cycle it lands in
            if (!abort) begin
                if (in_go)        wdog <= '0;
                else if (in_wait) wdog <= wdog + 1'b1;
                if (tmo)             err      <= 1'b1;
                if (state == COMMIT) iter_cnt <= iter_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        stg.s1_en    = (state == S1_GO);
        stg.s2_en    = (state == S2_GO);
        stg.s3_en    = (state == S3_GO);
        stg.alpha_we = (state == COMMIT);
        busy         = (state != IDLE);
        done         = (state == FIN);
    end
endmodule

// File: doc/pbvi_iter_ctrl.md
Name: pbvi_iter_ctrl

Overview:
Top-level sequencer for the PBVI value-backup loop. On each iteration it starts stage 1 (gamma projection), stage 2 (per-action gamma/belief build) and stage 3 (per-point argmax that produces alpha and point_action), one after another. After stage 3 it commits alpha to the alpha store. It repeats until the iteration limit is reached, the solver reports convergence, software aborts, or a stage hangs.

Parameters:
ITER_W, 8, width of the iteration limit and iteration counter
TO_W, 6, width of the per-stage watchdog counter
TIMEOUT, 48, cycles allowed in a stage WAIT state before error; must be less than 2**TO_W

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; honoured only in IDLE
abort  input  1  cancel the current run; honoured in any non-IDLE state
max_iter  input  ITER_W  iteration limit; latched on an accepted start
converged  input  1  convergence flag; sampled only in CHECK
s1_done  input  1  stage 1 done, level
s2_done  input  1  stage 2 done, level
s3_done  input  1  stage 3 done, level (stage 3 en_loop)
s1_en  output  1  one-cycle start pulse to stage 1
s2_en  output  1  one-cycle start pulse to stage 2
s3_en  output  1  one-cycle start pulse to stage 3
alpha_we  output  1  one-cycle write strobe: capture stage 3 alpha/point_action
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on normal completion
err  output  1  sticky stage-timeout flag
iter_cnt  output  ITER_W  number of completed (committed) iterations

Behaviour:
- Single clock clk. Reset rst_n is asynchronous, active-low. On reset: state=IDLE; every output=0; limit, watchdog and edge registers cleared.
- All outputs decode from registered state or counters only. No combinational path from any input to any output.
- States: IDLE, S1_GO, S1_WAIT, S2_GO, S2_WAIT, S3_GO, S3_WAIT, COMMIT, CHECK, FIN.
- IDLE: on start=1, latch max_iter, set iter_cnt<=0 and err<=0.
  - If the latched max_iter is 0, go to FIN.
  - Otherwise go to S1_GO.
- Sk_GO: sk_en=1 for exactly this cycle; watchdog<=0; go to Sk_WAIT.
- Sk_WAIT:
  - Each done input has a 1-bit previous-value register updated every cycle.
  - Stage k completes only on a 0->1 edge: sk_done=1 while its previous value=0. A done that is stale-high on entry is ignored until it falls and rises again.
  - On the edge: S1->S2_GO, S2->S3_GO, S3->COMMIT.
  - Otherwise watchdog increments. When watchdog reaches TIMEOUT-1 without an edge: err<=1, state<=IDLE, no done pulse.
- COMMIT: alpha_we=1 for one cycle; iter_cnt<=iter_cnt+1; go to CHECK.
- CHECK:
  - If converged=1 or iter_cnt==latched limit, go to FIN.
  - Otherwise go to S1_GO.
  - iter_cnt never wraps, because the limit is no greater than 2**ITER_W-1.
- FIN: done=1 for one cycle; go to IDLE. iter_cnt holds its value until the next accepted start.
- abort=1 in any non-IDLE state: state<=IDLE next cycle.
  - No done, no alpha_we.
  - A pulse already asserted this cycle completes; none is issued afterwards.
  - iter_cnt holds.
  - abort takes priority over any done edge, timeout or transition in the same cycle.
- start is ignored outside IDLE. start and abort together in IDLE: start wins, because abort has no effect in IDLE.
- Minimum iteration latency with done edges one cycle after each en is 8 cycles: 3 GO + 3 WAIT + COMMIT + CHECK.
- Run latency: accepted start to done = 8*N + 2 cycles for N iterations.
- busy=1 from the cycle after an accepted start through FIN inclusive.
- Reset mid-run: immediate return to reset values. No pulses are emitted while rst_n=0 or in the first cycle after release.

Test Plan:
- Reset release, start with max_iter=3, every stage responder raises done 1 cycle after its en -> exactly 3 each of s1_en/s2_en/s3_en/alpha_we, in order 1,2,3,we per iteration; done pulses 26 cycles after start; iter_cnt=3; busy drops the cycle after done.
- max_iter=10, converged asserted during iteration 4's CHECK -> done after 4 alpha_we; iter_cnt=4; no 5th s1_en.
- max_iter=0 -> no stage enables, no alpha_we; done 2 cycles after start; iter_cnt=0.
- s2 responder never raises done, TIMEOUT=48 -> err=1 exactly 48 cycles after s2_en's WAIT entry; state IDLE; no done; next start clears err.
- s3_done held high from before S3_GO (stale), then dropped and re-raised 5 cycles later -> COMMIT only after the re-raise edge.
- abort in S2_WAIT coincident with the s2_done edge -> IDLE next cycle; no s3_en, no alpha_we, no done; iter_cnt unchanged.
- Repeat: start pulsed mid-run -> ignored; rst_n dropped mid-S3_WAIT -> all outputs 0 immediately.
